swb: RTL and testbench
======================

Name: swb

Overview:
- Scalar writeback stage. Consumes the scalar ALU result one cycle after issue and retires the instruction.
- ALU ops: writes the register file. Branches and jumps: resolves control flow and emits a redirect.
- Loads and stores: runs a byte-serial memory state machine on the 8-bit memory bus and holds `busy` high to stall issue.

Parameters:
- ADDR_W, 32, memory address width.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region (stores to it obey io_buffer_full).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- wb_valid  in  1  instruction present this cycle (registered issue_rdy)
- is_vec  in  1  vector instruction; ignored by this block
- name  in  6  instruction encoding from the shared instruction define header
- rd  in  5  destination register
- pc  in  32  instruction pc
- imm  in  32  immediate
- val  in  32  ALU result (sum/address/compare bit)
- op2  in  32  rs2 value (store data)
- rf_we  out  1  regfile write pulse
- rf_rd  out  5  write index
- rf_data  out  32  write data
- br_taken  out  1  redirect pulse
- br_target  out  32  redirect pc
- mem_din  in  8  memory read byte
- mem_dout  out  8  memory write byte
- mem_a  out  ADDR_W  memory byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full
- busy  out  1  stall to IQueue

Behaviour:
- Reset (async): every output 0; state IDLE; byte counter 0.
- rdy=0: no state change, outputs hold.
- Instruction accept: in IDLE, an instruction is accepted at edge E0 when wb_valid=1, is_vec=0 and rdy=1.
- wb_valid while busy=1: illegal; ignored; flagged by a bench assertion.
- Pulses: rf_we and br_taken are single-cycle pulses, low in every other cycle.
- rd=0: rf_we is never asserted; all other effects still occur.
- ALU / LUI / AUIPC: at E0, rf_we=1, rf_rd=rd, rf_data=val. Latency 1 cycle.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): at E0, br_taken=val[0], br_target=pc+imm. No register write.
- JAL: at E0, br_taken=1, br_target=pc+imm, rf_data=pc+4.
- JALR: at E0, br_taken=1, br_target=val & ~1, rf_data=pc+4.
- Access size N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Load entry: at E0, state←LOAD, busy=1, mem_wr=0, mem_a=val.
- Load sequence:
  - mem_a=val+i is driven in the cycle after E_i, for i=0..N-1.
  - Byte i is returned on mem_din and captured at E_{i+2}; byte i goes to result bits [8i+7:8i].
  - At E_{N+1}: rf_we=1 with the assembled data, busy=0, state←IDLE.
  - LW therefore writes 5 cycles after accept.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store entry: at E0, state←STORE, busy=1.
- Store sequence:
  - For i=0..N-1, one cycle each: mem_a=val+i, mem_dout=op2[8i+7:8i], mem_wr=1.
  - Bytes are little-endian.
  - After the last byte: mem_wr=0, busy=0, state←IDLE.
- IO stall: if val[17:16]==IO_HI and io_buffer_full=1, the pending byte is held with mem_wr=0 and the counter frozen. The sequence resumes the cycle after io_buffer_full falls.
- Address arithmetic: wraps modulo 2^ADDR_W. Byte counter is 2 bits.
- Reset mid-load or mid-store: immediate return to IDLE; mem_wr=0; no rf_we; partial store bytes remain written.

Test Plan:
- ADD, rd=5, val=7 → one rf_we pulse the cycle after accept with rf_rd=5, rf_data=7. Same op with rd=0 → rf_we stays 0.
- BEQ, val=1, pc=0x100, imm=0xFFFFFFF8 → br_taken pulse, br_target=0xF8. Same op with val=0 → br_taken=0.
- JALR, val=0x203, pc=0x40, rd=1 → br_target=0x202, rf_data=0x44, both pulses in the same cycle.
- LB at val=0x10, memory byte 0x80 → rf_data=0xFFFFFF80; LBU gives 0x80. LW at 0x20 holding bytes 11 22 33 44 → rf_data=0x44332211, busy high for exactly 5 cycles, rf_we on the 5th.
- SW op2=0xAABBCCDD to val=0x30000 with io_buffer_full=1 for 3 cycles → no mem_wr during the stall. Then 4 writes: DD, CC, BB, AA at 0x30000..0x30003.
- Assert rst during byte 2 of an SW → mem_wr=0 and busy=0 immediately; the next ADD is accepted and retires normally.

Source files
------------

// File: rtl/swb_if.sv
// Byte-wide memory bus between the writeback stage and the data memory / IO buffer.
interface swb_if #(
   parameter int ADDR_W = 32
);
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;

   modport master (
      input  mem_din, io_buffer_full,
      output mem_dout, mem_a, mem_wr
   );

   modport slave (
      output mem_din, io_buffer_full,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/swb.sv
// Scalar writeback stage: retires ALU ops, resolves branches/jumps and runs
// byte-serial loads and stores on the 8-bit memory bus while holding busy.
module swb #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        wb_valid,
   input  logic        is_vec,
   input  logic [5:0]  name,
   input  logic [4:0]  rd,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] val,
   input  logic [31:0] op2,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic        br_taken,
   output logic [31:0] br_target,
   swb_if.master       mem,
   output logic        busy
);
   localparam logic [5:0] OP_JAL  = 6'd3,  OP_JALR = 6'd4;
   localparam logic [5:0] OP_BEQ  = 6'd5,  OP_BNE  = 6'd6,  OP_BLT = 6'd7;
   localparam logic [5:0] OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU = 6'd10;
   localparam logic [5:0] OP_LB   = 6'd11, OP_LH   = 6'd12, OP_LW  = 6'd13;
   localparam logic [5:0] OP_LBU  = 6'd14, OP_LHU  = 6'd15;
   localparam logic [5:0] OP_SB   = 6'd16, OP_SH   = 6'd17, OP_SW  = 6'd18;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;
   typedef enum logic [2:0] {C_ALU, C_BR, C_JAL, C_JALR, C_LD, C_ST} cls_t;

   state_t            state;
   cls_t              cls;
   logic [1:0]        acc_sz;      // access size minus one: 0, 1 or 3
   logic              acc_sgn;
   logic [1:0]        sz;
   logic              sgn;
   logic [1:0]        cnt;
   logic              first;
   logic              done;
   logic              io;
   logic [4:0]        ld_rd;
   logic [ADDR_W-1:0] base;
   logic [31:0]       st_data;
   logic [31:0]       ld_buf;
   logic [31:0]       ld_word;
   logic [31:0]       ld_ext;
   logic [7:0]        st_byte;

   always_comb begin
      cls     = C_ALU;
      acc_sz  = 2'd0;
      acc_sgn = 1'b0;
      case (name)
         OP_JAL:  cls = C_JAL;
         OP_JALR: cls = C_JALR;
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: cls = C_BR;
         OP_LB:   begin cls = C_LD; acc_sgn = 1'b1; end
         OP_LH:   begin cls = C_LD; acc_sz = 2'd1; acc_sgn = 1'b1; end
         OP_LW:   begin cls = C_LD; acc_sz = 2'd3; end
         OP_LBU:  cls = C_LD;
         OP_LHU:  begin cls = C_LD; acc_sz = 2'd1; end
         OP_SB:   cls = C_ST;
         OP_SH:   begin cls = C_ST; acc_sz = 2'd1; end
         OP_SW:   begin cls = C_ST; acc_sz = 2'd3; end
         default: ;
      endcase
   end

   // The byte arriving this cycle is merged in so the final write uses it directly.
   always_comb begin
      ld_word = ld_buf;
      case (cnt)
         2'd0: ld_word[7:0]   = mem.mem_din;
         2'd1: ld_word[15:8]  = mem.mem_din;
         2'd2: ld_word[23:16] = mem.mem_din;
         default: ld_word[31:24] = mem.mem_din;
      endcase
      case (sz)
         2'd0:    ld_ext = sgn ? {{24{ld_word[7]}}, ld_word[7:0]}   : {24'd0, ld_word[7:0]};
         2'd1:    ld_ext = sgn ? {{16{ld_word[15]}}, ld_word[15:0]} : {16'd0, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
      case (cnt)
         2'd0:    st_byte = st_data[7:0];
         2'd1:    st_byte = st_data[15:8];
         2'd2:    st_byte = st_data[23:16];
         default: st_byte = st_data[31:24];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         rf_we        <= 1'b0;
         rf_rd        <= '0;
         rf_data      <= '0;
         br_taken     <= 1'b0;
         br_target    <= '0;
         mem.mem_dout <= '0;
         mem.mem_a    <= '0;
         mem.mem_wr   <= 1'b0;
         busy         <= 1'b0;
         sz           <= '0;
         sgn          <= 1'b0;
         cnt          <= '0;
         first        <= 1'b0;
         done         <= 1'b0;
         io           <= 1'b0;
         ld_rd        <= '0;
         base         <= '0;
         st_data      <= '0;
         ld_buf       <= '0;
      end else if (rdy) begin
         rf_we    <= 1'b0;
         br_taken <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wb_valid && !is_vec) begin
                  sz      <= acc_sz;
                  sgn     <= acc_sgn;
                  cnt     <= '0;
                  first   <= 1'b1;
                  done    <= 1'b0;
                  io      <= (val[17:16] == IO_HI);
                  ld_rd   <= rd;
                  base    <= ADDR_W'(val);
                  st_data <= op2;
                  ld_buf  <= '0;
                  case (cls)
                     C_BR: begin
                        br_taken  <= val[0];
                        br_target <= pc + imm;
                     end
                     C_JAL, C_JALR: begin
                        br_taken  <= 1'b1;
                        br_target <= (cls == C_JAL) ? pc + imm : (val & ~32'd1);
                        rf_we     <= (rd != 5'd0);
                        rf_rd     <= rd;
                        rf_data   <= pc + 32'd4;
                     end
                     C_LD: begin
                        state      <= S_LOAD;
                        busy       <= 1'b1;
                        mem.mem_wr <= 1'b0;
                        mem.mem_a  <= ADDR_W'(val);
                     end
                     C_ST: begin
                        state <= S_STORE;
                        busy  <= 1'b1;
                     end
                     default: begin
                        rf_we   <= (rd != 5'd0);
                        rf_rd   <= rd;
                        rf_data <= val;
                     end
                  endcase
               end
            end
            // Memory returns data one cycle after the address, so capture lags issue by two edges.
            S_LOAD: begin
               if (first) begin
                  first <= 1'b0;
                  if (sz != 2'd0) mem.mem_a <= base + ADDR_W'(1);
               end else begin
                  ld_buf <= ld_word;
                  cnt    <= cnt + 2'd1;
                  if (({1'b0, cnt} + 3'd2) <= {1'b0, sz})
                     mem.mem_a <= base + ADDR_W'({1'b0, cnt} + 3'd2);
                  if (cnt == sz) begin
                     rf_we   <= (ld_rd != 5'd0);
                     rf_rd   <= ld_rd;
                     rf_data <= ld_ext;
                     busy    <= 1'b0;
                     state   <= S_IDLE;
                  end
               end
            end
            S_STORE: begin
               if (done) begin
                  mem.mem_wr <= 1'b0;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end else if (io && mem.io_buffer_full) begin
                  mem.mem_wr <= 1'b0;
               end else begin
                  mem.mem_a    <= base + ADDR_W'(cnt);
                  mem.mem_dout <= st_byte;
                  mem.mem_wr   <= 1'b1;
                  cnt          <= cnt + 2'd1;
                  done         <= (cnt == sz);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_swb.sv
// Directed self-checking bench for swb with a one-cycle-latency byte memory model.
module tb_swb;
   localparam logic [5:0] ADD = 6'd28, BEQ = 6'd5, JAL = 6'd3, JALR = 6'd4;
   localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
   localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

   logic        clk = 1'b0;
   logic        rst, rdy, wb_valid, is_vec;
   logic [5:0]  name;
   logic [4:0]  rd;
   logic [31:0] pc, imm, val, op2;
   logic        rf_we, br_taken, busy;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data, br_target;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  mem_arr [256];
   logic [31:0] wa [$];
   logic [7:0]  wd [$];

   swb_if #(.ADDR_W(32)) bus ();

   swb #(.ADDR_W(32), .IO_HI(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .wb_valid(wb_valid), .is_vec(is_vec),
      .name(name), .rd(rd), .pc(pc), .imm(imm), .val(val), .op2(op2),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
      .br_taken(br_taken), .br_target(br_target), .mem(bus), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.mem_din <= mem_arr[bus.mem_a[7:0]];

   always @(posedge clk) begin
      if (!rst && bus.mem_wr) begin
         wa.push_back(bus.mem_a);
         wd.push_back(bus.mem_dout);
      end
   end

   always @(posedge clk) begin
      if (!rst) assert (!(wb_valid && busy)) else $error("wb_valid asserted while busy");
   end

   task automatic issue(input logic [5:0] n, input logic [4:0] r, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] v, input logic [31:0] o);
      @(negedge clk);
      name = n; rd = r; pc = p; imm = i; val = v; op2 = o; wb_valid = 1'b1;
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({rf_we, rf_rd, rf_data, br_taken, br_target, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_wb got we=%b rd=%0d data=%h bt=%b tgt=%h busy=%b exp all 0",
                  rf_we, rf_rd, rf_data, br_taken, br_target, busy);
      end
      n_vec++;
      if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== '0) begin
         n_err++;
         $display("FAIL reset_mem got wr=%b a=%h dout=%h exp 0", bus.mem_wr, bus.mem_a, bus.mem_dout);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu;
      issue(ADD, 5'd5, 32'h0, 32'h0, 32'd7, 32'h0);
      n_vec++;
      if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd5, 32'd7}) begin
         n_err++;
         $display("FAIL alu_wr got we=%b rd=%0d data=%h exp 1/5/7", rf_we, rf_rd, rf_data);
      end
      @(negedge clk);
      n_vec++;
      if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_pulse got we=%b exp 0", rf_we); end
      issue(ADD, 5'd0, 32'h0, 32'h0, 32'd9, 32'h0);
      n_vec++;
      if ({rf_we, rf_data} !== {1'b0, 32'd9}) begin
         n_err++;
         $display("FAIL alu_rd0 got we=%b data=%h exp 0/9", rf_we, rf_data);
      end
   endtask

   task automatic test_rdy;
      rdy = 1'b0;
      issue(ADD, 5'd3, 32'h0, 32'h0, 32'h55, 32'h0);
      rdy = 1'b1;
      n_vec++;
      if ({rf_we, rf_data} !== {1'b0, 32'd9}) begin
         n_err++;
         $display("FAIL rdy_low_issue got we=%b data=%h exp 0/9", rf_we, rf_data);
      end
      is_vec = 1'b1;
      issue(ADD, 5'd3, 32'h0, 32'h0, 32'h56, 32'h0);
      is_vec = 1'b0;
      n_vec++;
      if ({rf_we, rf_data} !== {1'b0, 32'd9}) begin
         n_err++;
         $display("FAIL is_vec got we=%b data=%h exp 0/9", rf_we, rf_data);
      end
      issue(ADD, 5'd4, 32'h0, 32'h0, 32'h66, 32'h0);
      rdy = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd4, 32'h66}) begin
         n_err++;
         $display("FAIL rdy_hold got we=%b rd=%0d data=%h exp 1/4/66", rf_we, rf_rd, rf_data);
      end
      rdy = 1'b1;
      @(negedge clk);
      n_vec++;
      if (rf_we !== 1'b0) begin n_err++; $display("FAIL rdy_release got we=%b exp 0", rf_we); end
   endtask

   task automatic test_branch;
      issue(BEQ, 5'd9, 32'h100, 32'hFFFF_FFF8, 32'd1, 32'h0);
      n_vec++;
      if ({br_taken, br_target, rf_we} !== {1'b1, 32'hF8, 1'b0}) begin
         n_err++;
         $display("FAIL beq_taken got bt=%b tgt=%h we=%b exp 1/f8/0", br_taken, br_target, rf_we);
      end
      @(negedge clk);
      n_vec++;
      if (br_taken !== 1'b0) begin n_err++; $display("FAIL beq_pulse got bt=%b exp 0", br_taken); end
      issue(BEQ, 5'd9, 32'h100, 32'hFFFF_FFF8, 32'd0, 32'h0);
      n_vec++;
      if ({br_taken, br_target} !== {1'b0, 32'hF8}) begin
         n_err++;
         $display("FAIL beq_not_taken got bt=%b tgt=%h exp 0/f8", br_taken, br_target);
      end
   endtask

   task automatic test_jump;
      issue(JAL, 5'd2, 32'h1000, 32'h20, 32'h0, 32'h0);
      n_vec++;
      if ({br_taken, br_target, rf_we, rf_rd, rf_data} !== {1'b1, 32'h1020, 1'b1, 5'd2, 32'h1004}) begin
         n_err++;
         $display("FAIL jal got bt=%b tgt=%h we=%b rd=%0d data=%h exp 1/1020/1/2/1004",
                  br_taken, br_target, rf_we, rf_rd, rf_data);
      end
      issue(JALR, 5'd1, 32'h40, 32'h0, 32'h203, 32'h0);
      n_vec++;
      if ({br_taken, br_target, rf_we, rf_rd, rf_data} !== {1'b1, 32'h202, 1'b1, 5'd1, 32'h44}) begin
         n_err++;
         $display("FAIL jalr got bt=%b tgt=%h we=%b rd=%0d data=%h exp 1/202/1/1/44",
                  br_taken, br_target, rf_we, rf_rd, rf_data);
      end
   endtask

   task automatic do_load(input string tag, input logic [5:0] n, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] exp, input int nb);
      int we_at, we_n, busy_n;
      we_at = -1; we_n = 0; busy_n = 0;
      issue(n, r, 32'h0, 32'h0, a, 32'h0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         if (busy) busy_n++;
         if (k < nb) begin
            n_vec++;
            if (bus.mem_a !== a + 32'(k) || bus.mem_wr !== 1'b0) begin
               n_err++;
               $display("FAIL %s addr%0d got a=%h wr=%b exp a=%h wr=0", tag, k, bus.mem_a, bus.mem_wr, a + 32'(k));
            end
         end
         if (rf_we) begin
            we_n++;
            if (we_at < 0) we_at = k;
            n_vec++;
            if ({rf_rd, rf_data} !== {r, exp}) begin
               n_err++;
               $display("FAIL %s data got rd=%0d data=%h exp rd=%0d data=%h", tag, rf_rd, rf_data, r, exp);
            end
         end
      end
      n_vec++;
      if (busy_n != nb + 1) begin
         n_err++;
         $display("FAIL %s busy_len got %0d exp %0d", tag, busy_n, nb + 1);
      end
      n_vec++;
      if (r != 5'd0 && (we_at != nb + 1 || we_n != 1)) begin
         n_err++;
         $display("FAIL %s we_timing got at=%0d count=%0d exp at=%0d count=1", tag, we_at, we_n, nb + 1);
      end else if (r == 5'd0 && we_n != 0) begin
         n_err++;
         $display("FAIL %s rd0_we got count=%0d exp 0", tag, we_n);
      end
   endtask

   task automatic test_load;
      mem_arr[8'h10] = 8'h80;
      mem_arr[8'h20] = 8'h11; mem_arr[8'h21] = 8'h22; mem_arr[8'h22] = 8'h33; mem_arr[8'h23] = 8'h44;
      mem_arr[8'h40] = 8'h34; mem_arr[8'h41] = 8'h92;
      mem_arr[8'hFE] = 8'hA1; mem_arr[8'hFF] = 8'hB2; mem_arr[8'h00] = 8'hC3; mem_arr[8'h01] = 8'hD4;
      do_load("lb",   LB,  32'h10, 5'd6, 32'hFFFF_FF80, 1);
      do_load("lbu",  LBU, 32'h10, 5'd6, 32'h0000_0080, 1);
      do_load("lh",   LH,  32'h40, 5'd7, 32'hFFFF_9234, 2);
      do_load("lhu",  LHU, 32'h40, 5'd7, 32'h0000_9234, 2);
      do_load("lw",   LW,  32'h20, 5'd8, 32'h4433_2211, 4);
      do_load("lw_wrap", LW, 32'hFFFF_FFFE, 5'd9, 32'hD4C3_B2A1, 4);
      do_load("lw_rd0", LW, 32'h20, 5'd0, 32'h4433_2211, 4);
   endtask

   task automatic do_store(input string tag, input logic [5:0] n, input logic [31:0] a,
                           input logic [31:0] d, input int nb, input logic io_lvl,
                           input int hold, input int exp_stall);
      int b0, idle_at;
      b0 = wa.size(); idle_at = -1;
      bus.io_buffer_full = io_lvl;
      issue(n, 5'd0, 32'h0, 32'h0, a, d);
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         if (k <= exp_stall) begin
            n_vec++;
            if (bus.mem_wr !== 1'b0) begin
               n_err++;
               $display("FAIL %s stall%0d got wr=%b exp 0", tag, k, bus.mem_wr);
            end
         end
         if (k == hold) bus.io_buffer_full = 1'b0;
         if (!busy) begin idle_at = k; break; end
      end
      bus.io_buffer_full = 1'b0;
      n_vec++;
      if (idle_at != exp_stall + nb + 1) begin
         n_err++;
         $display("FAIL %s busy_end got %0d exp %0d", tag, idle_at, exp_stall + nb + 1);
      end
      n_vec++;
      if (wa.size() - b0 != nb) begin
         n_err++;
         $display("FAIL %s wr_count got %0d exp %0d", tag, wa.size() - b0, nb);
      end else begin
         for (int i = 0; i < nb; i++) begin
            n_vec++;
            if (wa[b0 + i] !== a + 32'(i) || wd[b0 + i] !== d[8*i +: 8]) begin
               n_err++;
               $display("FAIL %s byte%0d got a=%h d=%h exp a=%h d=%h", tag, i, wa[b0 + i], wd[b0 + i],
                        a + 32'(i), d[8*i +: 8]);
            end
         end
      end
   endtask

   task automatic test_store;
      do_store("sw_io",  SW, 32'h0003_0000, 32'hAABB_CCDD, 4, 1'b1, 3, 3);
      do_store("sb_mem", SB, 32'h0000_0100, 32'h0000_005A, 1, 1'b1, 3, 0);
      do_store("sh_io",  SH, 32'h0003_FFFE, 32'h0000_1234, 2, 1'b0, 0, 0);
   endtask

   task automatic test_reset_mid_store;
      int b0;
      b0 = wa.size();
      issue(SW, 5'd0, 32'h0, 32'h0, 32'h200, 32'h0102_0304);
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h202, 8'h02}) begin
         n_err++;
         $display("FAIL rst_pre got wr=%b a=%h d=%h exp 1/202/02", bus.mem_wr, bus.mem_a, bus.mem_dout);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.mem_wr, busy, rf_we} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_mid got wr=%b busy=%b we=%b exp 000", bus.mem_wr, busy, rf_we);
      end
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (wa.size() - b0 != 2) begin
         n_err++;
         $display("FAIL rst_partial got %0d writes exp 2", wa.size() - b0);
      end
      issue(ADD, 5'd7, 32'h0, 32'h0, 32'h77, 32'h0);
      n_vec++;
      if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd7, 32'h77}) begin
         n_err++;
         $display("FAIL rst_next_add got we=%b rd=%0d data=%h exp 1/7/77", rf_we, rf_rd, rf_data);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      name = ADD; rd = 5'd10; val = 32'h1; wb_valid = 1'b1;
      @(negedge clk);
      rd = 5'd11; val = 32'h2;
      n_vec++;
      if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd10, 32'h1}) begin
         n_err++;
         $display("FAIL b2b_first got we=%b rd=%0d data=%h exp 1/10/1", rf_we, rf_rd, rf_data);
      end
      @(negedge clk);
      wb_valid = 1'b0;
      n_vec++;
      if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd11, 32'h2}) begin
         n_err++;
         $display("FAIL b2b_second got we=%b rd=%0d data=%h exp 1/11/2", rf_we, rf_rd, rf_data);
      end
      @(negedge clk);
      n_vec++;
      if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_end got we=%b exp 0", rf_we); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
      rst = 1'b1; rdy = 1'b1; wb_valid = 1'b0; is_vec = 1'b0;
      name = '0; rd = '0; pc = '0; imm = '0; val = '0; op2 = '0;
      bus.io_buffer_full = 1'b0;
      test_reset;
      test_alu;
      test_rdy;
      test_branch;
      test_jump;
      test_load;
      test_store;
      test_reset_mid_store;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
